// File: rtl/alu_pkg.sv
// alu_pkg
// Definitions shared by the ALU writeback stage and the branch unit:
// - condition-code encoding (cond_e)
// - bit positions of the n, z, c, v flags inside a 4-bit flag vector
package alu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check
// Purely combinational condition evaluator. It is shared with the branch unit.
// Ports:
//   cond  - 4-bit condition code (cond_e encoding)
//   flags - flag vector {n,z,c,v}
//   pass  - 1 when the condition holds. Codes E and F always pass.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_cond_writeback.sv
// alu_cond_writeback
// Conditional writeback stage that sits directly after the ALU.
// Each accepted ALU result is first checked against the architectural flags.
// - Instructions whose condition passes may update the flags.
// - Those same instructions may also queue a register-file write in a
//   one-entry valid/ready output register.
// - Instructions whose condition fails are squashed and counted in a
//   saturating counter.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   in_valid/in_ready                - ALU-side handshake
//   in_result, in_flags, in_cond     - ALU result, raw {n,z,c,v}, condition
//   in_set_flags, in_reg_write       - instruction side effects
//   in_rd                            - destination register
//   out_valid/out_ready              - register-file side handshake
//   out_data, out_rd                 - pending write
//   flags_q                          - architectural flags {n,z,c,v}
//   squash_cnt                       - saturating count of failed conditions
module alu_cond_writeback
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_result,
  input  logic [3:0]            in_flags,
  input  logic [3:0]            in_cond,
  input  logic                  in_set_flags,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [3:0]            flags_q,
  output logic [CNT_W-1:0]      squash_cnt
);

  logic pass;
  logic accept;
  logic xfer;

  // The condition sees only the registered flags. There is no bypass from
  // in_flags, so a flag-setting instruction affects the next accept onward.
  cond_check u_cond_check (
    .cond  (in_cond),
    .flags (flags_q),
    .pass  (pass)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_rd     <= '0;
      flags_q    <= 4'b0000;
      squash_cnt <= '0;
    end else begin
      if (accept && pass) begin
        if (in_set_flags) begin
          flags_q <= in_flags;
        end
        // A new write may overwrite an entry that transfers this same cycle.
        if (in_reg_write) begin
          out_data  <= in_result;
          out_rd    <= in_rd;
          out_valid <= 1'b1;
        end else if (xfer) begin
          out_valid <= 1'b0;
        end
      end else begin
        if (accept && (squash_cnt != '1)) begin
          squash_cnt <= squash_cnt + CNT_W'(1);
        end
        if (xfer) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cond_writeback.sv
module tb_alu_cond_writeback;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [3:0]  in_cond;
  logic        in_set_flags;
  logic        in_reg_write;
  logic [3:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_rd;
  logic [3:0]  flags_q;
  logic [15:0] squash_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  // Reference model state
  logic [3:0] m_flags  = 4'b0000;
  int         m_squash = 0;
  logic       m_valid  = 1'b0;

  alu_cond_writeback #(
    .WIDTH      (32),
    .REG_ADDR_W (4),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_cond      (in_cond),
    .in_set_flags (in_set_flags),
    .in_reg_write (in_reg_write),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .flags_q      (flags_q),
    .squash_cnt   (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Even codes select a base predicate; odd codes below 14 are its inverse.
  function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond >> 1)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (cond < 4'd14) ? (base ^ cond[0]) : 1'b1;
  endfunction

  // Reference model: runs between edges, predicts the effect of the next edge.
  always @(negedge clk) begin
    logic exp_rdy, acc, xfer, wr;
    if (!rst_n) begin
      m_flags  = 4'b0000;
      m_squash = 0;
      m_valid  = 1'b0;
      exp_q.delete();
    end else begin
      exp_rdy = !m_valid || out_ready;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("flags_q", 32'(flags_q), 32'(m_flags));
      chk("squash_cnt", 32'(squash_cnt), 32'(m_squash));
      acc  = in_valid && exp_rdy;
      xfer = m_valid && out_ready;
      wr   = 1'b0;
      if (acc) begin
        if (ref_pass(in_cond, m_flags)) begin
          if (in_set_flags) m_flags = in_flags;
          if (in_reg_write) begin
            exp_q.push_back('{rd: in_rd, data: in_result});
            wr = 1'b1;
          end
        end else if (m_squash < 65535) begin
          m_squash = m_squash + 1;
        end
      end
      m_valid = wr ? 1'b1 : (xfer ? 1'b0 : m_valid);
    end
  end

  // Monitor: compares every register-file transfer against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", out_data, e.data);
        chk("wr_rd", 32'(out_rd), 32'(e.rd));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] f,
                       input logic [3:0] cond, input logic sf, input logic rw,
                       input logic [3:0] rd, input logic ordy);
    @(posedge clk);
    #1;
    in_valid     = v;
    in_result    = res;
    in_flags     = f;
    in_cond      = cond;
    in_set_flags = sf;
    in_reg_write = rw;
    in_rd        = rd;
    out_ready    = ordy;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, $urandom, 4'($urandom), 4'($urandom), 1'b0, 1'b0, 4'($urandom), ordy);
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_result    = '0;
    in_flags     = '0;
    in_cond      = '0;
    in_set_flags = 1'b0;
    in_reg_write = 1'b0;
    in_rd        = '0;
    out_ready    = 1'b1;

    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_squash", 32'(squash_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Flag-setting instruction followed by a dependent one, then a squash
    drive(1'b1, 32'h0, 4'b0100, 4'hE, 1'b1, 1'b1, 4'd3, 1'b1);
    drive(1'b1, 32'h1234, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd5, 1'b1);
    @(negedge clk);
    chk("subs_flags", 32'(flags_q), 32'h4);
    chk("subs_valid", 32'(out_valid), 32'd1);
    chk("subs_rd", 32'(out_rd), 32'd3);
    chk("subs_data", out_data, 32'd0);
    drive(1'b1, 32'hDEAD, 4'b1000, 4'h1, 1'b1, 1'b1, 4'd6, 1'b1);
    @(negedge clk);
    chk("eq_data", out_data, 32'h1234);
    chk("eq_rd", 32'(out_rd), 32'd5);
    idle(1'b1);
    @(negedge clk);
    chk("sq_flags", 32'(flags_q), 32'h4);
    chk("sq_cnt", 32'(squash_cnt), 32'd1);
    chk("sq_no_write", 32'(out_valid), 32'd0);

    // Backpressure: entry must hold while the register file stalls
    drive(1'b1, 32'hAAAA, 4'b0000, 4'hE, 1'b0, 1'b1, 4'd7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom, 4'($urandom), 4'hE, 1'b0, 1'b1, 4'd8, 1'b0);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_data_hold", out_data, 32'hAAAA);
      chk("bp_rd_hold", 32'(out_rd), 32'd7);
    end
    drive(1'b1, 32'hBEEF, 4'b0000, 4'hE, 1'b0, 1'b1, 4'd9, 1'b1);
    idle(1'b0);
    @(negedge clk);
    chk("bp_reload_valid", 32'(out_valid), 32'd1);
    chk("bp_reload_data", out_data, 32'hBEEF);
    chk("bp_reload_rd", 32'(out_rd), 32'd9);
    idle(1'b1);

    // Condition sweep: every code against every flag value
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(1'b1, $urandom, 4'(f), 4'hE, 1'b1, 1'b0, 4'($urandom), 1'b1);
        drive(1'b1, $urandom, 4'($urandom), 4'(c), 1'b0, 1'b1, 4'($urandom), 1'b1);
      end
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 4) != 0, $urandom, 4'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 4'($urandom), ($urandom % 4) != 0);
    end

    // Async reset while a write is pending
    idle(1'b1);
    drive(1'b1, 32'h5555, 4'b1111, 4'hE, 1'b1, 1'b1, 4'd2, 1'b0);
    idle(1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_flags", 32'(flags_q), 32'd0);
    chk("mid_rst_squash", 32'(squash_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Saturation: flags are zero, so EQ always fails
    for (int i = 0; i < 65539; i++) begin
      drive(1'b1, $urandom, 4'($urandom), 4'h0, 1'($urandom), 1'($urandom), 4'($urandom), 1'b1);
    end
    idle(1'b1);
    @(negedge clk);
    chk("sat_squash", 32'(squash_cnt), 32'hFFFF);

    for (int i = 0; i < 4; i++) idle(1'b1);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cond_writeback.md
Name: alu_cond_writeback

Overview:
- Stage directly downstream of the ALU.
- Takes each ALU result with its raw flags (n,z,c,v) and the instruction's condition code and destination.
- Evaluates the condition against the architectural flag register and updates that register when the instruction sets flags.
- Presents the register-file write through a one-entry valid/ready output register, and counts squashed (condition-failed) instructions.

Parameters:
- WIDTH, 32, data width of ALU result and write data
- REG_ADDR_W, 4, destination register address width
- CNT_W, 16, width of the squash counter

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  ALU result valid this cycle
- in_ready  output  1  stage can accept the input this cycle
- in_result  input  WIDTH  ALU result
- in_flags  input  4  ALU flags, order [3]=n [2]=z [1]=c [0]=v
- in_cond  input  4  condition code (encoding below)
- in_set_flags  input  1  instruction updates the flag register
- in_reg_write  input  1  instruction writes the register file
- in_rd  input  REG_ADDR_W  destination register
- out_valid  output  1  register-file write pending
- out_ready  input  1  register file consumes the write
- out_data  output  WIDTH  write data
- out_rd  output  REG_ADDR_W  write address
- flags_q  output  4  architectural flags n,z,c,v
- squash_cnt  output  CNT_W  count of condition-failed instructions, saturating

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_rd=0, flags_q=4'b0000, squash_cnt=0.
  - in_ready is combinational, so it reads 1 while in reset.
  - A reset mid-transaction drops any pending write.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Condition evaluation: combinational on in_cond and flags_q as registered before this cycle's edge. Encoding:
  - 0 EQ: z
  - 1 NE: !z
  - 2 CS: c
  - 3 CC: !c
  - 4 MI: n
  - 5 PL: !n
  - 6 VS: v
  - 7 VC: !v
  - 8 HI: c&!z
  - 9 LS: !c|z
  - A GE: n==v
  - B LT: n!=v
  - C GT: !z&(n==v)
  - D LE: z|(n!=v)
  - E, F: always pass
- On accept with pass=1:
  - If in_set_flags, flags_q <= in_flags at the same edge.
  - If in_reg_write, then out_data <= in_result, out_rd <= in_rd, out_valid <= 1.
  - If !in_reg_write, out_valid <= 0 when the old entry transfers this cycle; otherwise it holds.
- On accept with pass=0:
  - No flag update and no write.
  - squash_cnt increments and saturates at all-ones without wrapping.
  - out_valid follows the same clear/hold rule as !in_reg_write.
- No accept: out_valid clears on a transfer and holds otherwise. out_data and out_rd hold while out_valid=1 && !out_ready.
- Simultaneous transfer and accept: the new write replaces the old in the same cycle (full-throughput, one per cycle).
- Back-to-back flag dependency: the instruction accepted at cycle k+1 sees flags set by the one accepted at cycle k. No bypass of in_flags into the same cycle's condition.
- Latency: 1 cycle from accept to out_valid.
- in_* signals are don't-care when in_valid=0. Nothing changes without an accept.

Decomposition:
- Shared package alu_pkg:
  - cond_e enum (EQ..AL, 4-bit).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cond_check: pure combinational (cond, flags) -> pass. It is reused later by the branch unit.

Test Plan:
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid=0, flags_q=0, squash_cnt=0 immediately (async, no clock edge needed).
- Flag-setting then dependent instruction:
  - Accept SUBS (in_flags=4'b0100, cond=E, set_flags=1, reg_write=1, rd=3, result=0) -> next cycle flags_q=0100, out_valid=1, out_rd=3, out_data=0.
  - Then accept cond=0 EQ, rd=5, result=0x1234 -> out_data=0x1234, out_rd=5.
- Squash: with flags_q=0100, accept cond=1 NE, reg_write=1, set_flags=1, in_flags=1000 -> no write, flags_q stays 0100, squash_cnt=1.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_data/out_rd hold for 5 cycles. Raise out_ready -> transfer; with in_valid=1 the new entry loads the same cycle.
- Condition sweep: for all 16 codes x all 16 flag values, compare pass/squash against a reference model. GE/LT use n==v, HI/LS use c,z.
- Saturation: force 2^CNT_W+3 failed conditions -> squash_cnt stays at 16'hFFFF.
